ysyx_24100005_fetch_ctrl: RTL and testbench



---
 rtl/ysyx_24100005_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ysyx_24100005_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_fetch_ctrl.sv
// rtl/ysyx_24100005_fetch_ctrl.sv - instruction-fetch sequencer owning the PC
//
// Purpose: issues one instruction-memory request at a time from the PC, buffers
// the response for decode, advances PC by 4 when decode consumes the instruction,
// and overwrites PC on redirects (branch/jump/trap).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   halt                        blocks issue of new requests while in S_REQ
//   redirect_valid/redirect_pc  one-cycle redirect pulse and target
//   imem_req_*                  request channel (valid/ready, addr = PC)
//   imem_rsp_*                  response channel (always accepted)
//   inst_valid/inst_ready       buffered instruction handshake toward decode
//   inst, inst_pc, inst_fault   buffered instruction, its PC, access-fault flag
//   perf_fetch_cnt/perf_stall_cnt  only with YSYX_24100005_FETCH_PERF_EN defined
//
// Optional feature macro: YSYX_24100005_FETCH_PERF_EN

module ysyx_24100005_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
`ifdef YSYX_24100005_FETCH_PERF_EN
   ,output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_fault_q, inst_fault_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;

        // Request is masked while reset is held so nothing is accepted mid-reset.
        imem_req_valid = (state_q == S_REQ) && !halt && !rst;
        imem_req_addr  = pc_q;
        inst_valid     = (state_q == S_HOLD);
        inst           = inst_q;
        inst_pc        = inst_pc_q;
        inst_fault     = inst_fault_q;

        case (state_q)
            S_REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    state_d = S_WAIT;
                    // The accepted address is the old PC; its response must be thrown away.
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d       = imem_rsp_data;
                        inst_pc_d    = pc_q;
                        inst_fault_d = imem_rsp_err;
                        state_d      = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over the sequential PC+4 update in every state.
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

`ifdef YSYX_24100005_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (inst_valid && inst_ready) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if ((state_q == S_WAIT) || (imem_req_valid && !imem_req_ready)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_24100005_fetch_ctrl.sv
// tb/tb_ysyx_24100005_fetch_ctrl.sv - scoreboard bench for ysyx_24100005_fetch_ctrl

module tb_ysyx_24100005_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    ysyx_24100005_fetch_ctrl #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_deliv  = 0;
    int          n_fault  = 0;
    int          cyc      = 0;
    int          fire_cyc = 0;
    int          prev_fire_cyc = 0;
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          rsp_delay = 0;
    logic        pending = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    logic        last_req_fire = 1'b0;
    logic        last_inst_fire = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: observe handshakes, score them, advance the memory model.
    task automatic cycle();
        logic rf, ifr, rspf;
        logic [31:0] raddr;
        exp_t e;
        #1;
        rf    = imem_req_valid && imem_req_ready;
        ifr   = inst_valid && inst_ready;
        rspf  = imem_rsp_valid;
        raddr = imem_req_addr;
        if (inst_valid) begin
            if (sb.size() == 0) begin
                check_eq("inst_expected", 32'd0, 32'd1);
            end else begin
                e = sb[0];
                check_eq("inst", inst, e.data);
                check_eq("inst_pc", inst_pc, e.pc);
                check_eq("inst_fault", {31'b0, inst_fault}, {31'b0, e.err});
                if (ifr) begin
                    void'(sb.pop_front());
                    n_deliv++;
                    if (e.err) n_fault++;
                    exp_addr = e.pc + 32'd4;
                end
            end
        end
        if (rf) check_eq("req_addr", raddr, exp_addr);
        if (redirect_valid) begin
            // Everything in flight is discarded by a redirect.
            sb.delete();
            exp_addr = redirect_pc;
        end else if (rf) begin
            sb.push_back('{pc: exp_addr, data: mem_word(exp_addr), err: (exp_addr == err_addr)});
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (ifr) begin
            prev_fire_cyc = fire_cyc;
            fire_cyc = cyc;
        end
        if (rspf) pending = 1'b0;
        if (rf) begin
            pending   = 1'b1;
            pend_addr = raddr;
            pend_cnt  = rsp_delay;
        end
        if (pending && pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            imem_rsp_err   = (pend_addr == err_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            imem_rsp_err   = 1'b0;
            if (pending) pend_cnt--;
        end
        last_req_fire  = rf;
        last_inst_fire = ifr;
        #1;
    endtask

    task automatic run_until_deliv(input int n, input string tag);
        int target;
        target = n_deliv + n;
        for (int i = 0; i < 200 && n_deliv < target; i++) cycle();
        check_eq(tag, n_deliv, target);
    endtask

    task automatic wait_req_fire(input string tag);
        int i;
        cycle();
        for (i = 0; i < 100 && !last_req_fire; i++) cycle();
        check_eq(tag, {31'b0, last_req_fire}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0; inst_ready = 1'b1;
        #12;
        check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check_eq("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_pc", inst_pc, RESET_PC);
        check_eq("rst_inst_fault", {31'b0, inst_fault}, 32'd0);
        @(posedge clk); #1; rst = 1'b0; #1;

        // Back-to-back fetch: one instruction every 3 cycles.
        run_until_deliv(2, "p1_deliv_a");
        check_eq("p1_cadence_a", fire_cyc - prev_fire_cyc, 3);
        run_until_deliv(1, "p1_deliv_b");
        check_eq("p1_cadence_b", fire_cyc - prev_fire_cyc, 3);

        // Request held while memory is not ready.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("p2_req_held", {31'b0, imem_req_valid}, 32'd1);
            check_eq("p2_addr_stable", imem_req_addr, 32'h8000_000C);
            check_eq("p2_no_inst", {31'b0, inst_valid}, 32'd0);
        end
        imem_req_ready = 1'b1;
        run_until_deliv(1, "p2_deliv");

        // Redirect in S_WAIT with a slow response: that response is dropped.
        rsp_delay = 2;
        wait_req_fire("p3_req");
        redirect_pc = 32'h8000_1000; redirect_valid = 1'b1;
        cycle();
        rsp_delay = 0;
        run_until_deliv(2, "p3_deliv");

        // Decode stalls in S_HOLD, then a redirect arrives with inst_ready high.
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        check_eq("p4_hold_reached", {31'b0, inst_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("p4_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        redirect_pc = 32'h8000_2000; redirect_valid = 1'b1; inst_ready = 1'b1;
        cycle();
        run_until_deliv(1, "p4_deliv");

        // Redirect in S_REQ while the request is not accepted.
        imem_req_ready = 1'b0;
        cycle();
        redirect_pc = 32'h8000_3000; redirect_valid = 1'b1;
        cycle();
        check_eq("p5_req_addr_moved", imem_req_addr, 32'h8000_3000);
        imem_req_ready = 1'b1;
        run_until_deliv(1, "p5_deliv");

        // Redirect accepted same cycle in S_REQ, then an access fault at 0x80000004.
        err_addr = 32'h8000_0004;
        redirect_pc = RESET_PC; redirect_valid = 1'b1;
        cycle();
        run_until_deliv(3, "p6_deliv");
        check_eq("p6_fault_count", n_fault, 1);
        err_addr = 32'hFFFF_FFFF;

        // Halt in S_REQ: no requests.
        halt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_eq("p7_halt_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        halt = 1'b0;

        // Reset mid-S_WAIT; the late response must be ignored afterwards.
        rsp_delay = 2;
        wait_req_fire("p8_req");
        rst = 1'b1;
        #1;
        check_eq("p8_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check_eq("p8_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("p8_rst_pc", imem_req_addr, RESET_PC);
        check_eq("p8_rst_inst_pc", inst_pc, RESET_PC);
        check_eq("p8_rst_inst", inst, 32'h0);
        imem_req_ready = 1'b0;
        sb.delete();
        exp_addr = RESET_PC;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check_eq("p8_late_rsp_ignored", {31'b0, inst_valid}, 32'd0);
        rsp_delay = 0;
        imem_req_ready = 1'b1;
        run_until_deliv(2, "p8_deliv");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
